// File: rtl/pzcorebus_axi2corebus_simple_bridge.sv
// rtl/pzcorebus_axi2corebus_simple_bridge.sv - AXI4 slave to corebus master bridge with posted writes
`timescale 1ns/1ps
module pzcorebus_axi2corebus_simple_bridge #(
  parameter int ID_WIDTH               = 4,
  parameter int AXI_ADDR_WIDTH         = 32,
  parameter int COREBUS_ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH             = 32,
  parameter int LENGTH_WIDTH           = 8,
  parameter int MAX_OUTSTANDING_WRITES = 4,
  parameter bit SVA_CHECKER            = 1
)(
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic [ID_WIDTH-1:0]           axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]     axi_awaddr,
  input  logic [7:0]                    axi_awlen,
  input  logic [2:0]                    axi_awsize,
  input  logic [1:0]                    axi_awburst,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  input  logic [DATA_WIDTH-1:0]         axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]       axi_wstrb,
  input  logic                          axi_wlast,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  output logic [ID_WIDTH-1:0]           axi_bid,
  output logic [1:0]                    axi_bresp,
  input  logic                          axi_arvalid,
  output logic                          axi_arready,
  input  logic [ID_WIDTH-1:0]           axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]     axi_araddr,
  input  logic [7:0]                    axi_arlen,
  input  logic [2:0]                    axi_arsize,
  input  logic [1:0]                    axi_arburst,
  output logic                          axi_rvalid,
  input  logic                          axi_rready,
  output logic [ID_WIDTH-1:0]           axi_rid,
  output logic [DATA_WIDTH-1:0]         axi_rdata,
  output logic [1:0]                    axi_rresp,
  output logic                          axi_rlast,
  output logic                          corebus_mcmd_valid,
  input  logic                          corebus_scmd_accept,
  output logic [1:0]                    corebus_mcmd,
  output logic [ID_WIDTH-1:0]           corebus_mid,
  output logic [COREBUS_ADDR_WIDTH-1:0] corebus_maddr,
  output logic [LENGTH_WIDTH-1:0]       corebus_mlength,
  output logic                          corebus_mdata_valid,
  input  logic                          corebus_sdata_accept,
  output logic [DATA_WIDTH-1:0]         corebus_mdata,
  output logic [DATA_WIDTH/8-1:0]       corebus_mdata_byteen,
  output logic                          corebus_mdata_last,
  input  logic                          corebus_sresp_valid,
  output logic                          corebus_mresp_accept,
  input  logic                          corebus_sresp,
  input  logic [ID_WIDTH-1:0]           corebus_sid,
  input  logic                          corebus_serror,
  input  logic [DATA_WIDTH-1:0]         corebus_sdata,
  input  logic [1:0]                    corebus_sresp_last
);
  localparam logic [1:0] PZCOREBUS_READ               = 2'b01;
  localparam logic [1:0] PZCOREBUS_WRITE              = 2'b10;
  localparam logic       PZCOREBUS_RESPONSE_WITH_DATA = 1'b1;
  localparam logic [1:0] AXI_OKAY                     = 2'b00;
  localparam logic [1:0] AXI_SLVERR                   = 2'b10;
  localparam logic [1:0] AXI_INCR                     = 2'b01;
  localparam logic [2:0] FULL_SIZE = 3'($clog2(DATA_WIDTH / 8));
  localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING_WRITES + 1);
  localparam int PTR_WIDTH      = (MAX_OUTSTANDING_WRITES > 1) ? $clog2(MAX_OUTSTANDING_WRITES) : 1;
  localparam int ADDR_EXT_WIDTH = (AXI_ADDR_WIDTH > COREBUS_ADDR_WIDTH) ? AXI_ADDR_WIDTH : COREBUS_ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] FIFO_DEPTH    = CNT_WIDTH'(MAX_OUTSTANDING_WRITES);
  localparam logic [PTR_WIDTH-1:0] LAST_FIFO_PTR = PTR_WIDTH'(MAX_OUTSTANDING_WRITES - 1);

  logic                      lock_valid;
  logic                      lock_aw;
  logic                      prio_aw;
  logic                      sel_aw;
  logic                      aw_eligible;
  logic                      ar_eligible;
  logic                      cmd_valid;
  logic                      aw_hs;
  logic                      ar_hs;
  logic                      w_hs;
  logic                      wlast_hs;
  logic                      b_hs;
  logic                      data_gate;
  logic                      fifo_full;
  logic                      read_resp;
  logic [8:0]                burst_length;
  logic [ADDR_EXT_WIDTH-1:0] addr_ext;
  logic [CNT_WIDTH-1:0]      data_credit;
  logic [CNT_WIDTH-1:0]      done_count;
  logic [CNT_WIDTH-1:0]      fifo_count;
  logic [PTR_WIDTH-1:0]      wr_ptr;
  logic [PTR_WIDTH-1:0]      rd_ptr;
  logic [ID_WIDTH-1:0]       id_fifo [MAX_OUTSTANDING_WRITES];
  logic                      unused_inputs;

  function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == LAST_FIFO_PTR) ? '0 : ptr + 1'b1;
  endfunction

  assign fifo_full   = fifo_count == FIFO_DEPTH;
  assign aw_eligible = axi_awvalid && !fifo_full;
  assign ar_eligible = axi_arvalid;

  // A command already presented but not accepted keeps its side until scmd_accept.
  always_comb begin
    sel_aw = aw_eligible;
    if (lock_valid) begin
      sel_aw = lock_aw;
    end else if (aw_eligible && ar_eligible) begin
      sel_aw = prio_aw;
    end
  end

  // Command valid is gated by reset so an asserted reset silences the command channel at once.
  assign cmd_valid    = i_rst_n && (sel_aw ? aw_eligible : ar_eligible);
  assign aw_hs        = cmd_valid && sel_aw && corebus_scmd_accept;
  assign ar_hs        = cmd_valid && !sel_aw && corebus_scmd_accept;
  assign axi_awready  = aw_hs;
  assign axi_arready  = ar_hs;
  assign burst_length = {1'b0, (sel_aw ? axi_awlen : axi_arlen)} + 9'd1;
  assign addr_ext     = ADDR_EXT_WIDTH'(sel_aw ? axi_awaddr : axi_araddr);

  assign corebus_mcmd_valid = cmd_valid;
  assign corebus_mcmd       = sel_aw ? PZCOREBUS_WRITE : PZCOREBUS_READ;
  assign corebus_mid        = sel_aw ? axi_awid : axi_arid;
  assign corebus_maddr      = addr_ext[COREBUS_ADDR_WIDTH-1:0];
  assign corebus_mlength    = LENGTH_WIDTH'(burst_length);

  // Write data may only flow once its command has been issued, at the earliest in the same cycle.
  assign data_gate            = (data_credit != '0) || aw_hs;
  assign corebus_mdata_valid  = axi_wvalid && data_gate;
  assign axi_wready           = corebus_sdata_accept && data_gate;
  assign corebus_mdata        = axi_wdata;
  assign corebus_mdata_byteen = axi_wstrb;
  assign corebus_mdata_last   = axi_wlast;
  assign w_hs                 = axi_wvalid && axi_wready;
  assign wlast_hs             = w_hs && axi_wlast;

  assign axi_bvalid = done_count != '0;
  assign axi_bid    = id_fifo[rd_ptr];
  assign axi_bresp  = AXI_OKAY;
  assign b_hs       = axi_bvalid && axi_bready;

  // Write-type responses never belong to an AXI transaction and are silently consumed.
  assign read_resp            = corebus_sresp == PZCOREBUS_RESPONSE_WITH_DATA;
  assign axi_rvalid           = corebus_sresp_valid && read_resp;
  assign axi_rid              = corebus_sid;
  assign axi_rdata            = corebus_sdata;
  assign axi_rresp            = corebus_serror ? AXI_SLVERR : AXI_OKAY;
  assign axi_rlast            = corebus_sresp_last[0];
  assign corebus_mresp_accept = read_resp ? axi_rready : 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_valid  <= 1'b0;
      lock_aw     <= 1'b0;
      prio_aw     <= 1'b0;
      data_credit <= '0;
      done_count  <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      lock_valid  <= cmd_valid && !corebus_scmd_accept;
      lock_aw     <= sel_aw;
      if (cmd_valid && corebus_scmd_accept) begin
        prio_aw <= !sel_aw;
      end
      data_credit <= data_credit + CNT_WIDTH'(aw_hs) - CNT_WIDTH'(wlast_hs);
      done_count  <= done_count + CNT_WIDTH'(wlast_hs) - CNT_WIDTH'(b_hs);
      fifo_count  <= fifo_count + CNT_WIDTH'(aw_hs) - CNT_WIDTH'(b_hs);
      if (aw_hs) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (b_hs) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (aw_hs) begin
      id_fifo[wr_ptr] <= axi_awid;
    end
  end

  assign unused_inputs = ^{corebus_sresp_last[1], axi_awsize, axi_awburst, axi_arsize, axi_arburst};

  if (SVA_CHECKER) begin : g_sva
    ast_aw_incr_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      axi_awvalid |-> (axi_awburst == AXI_INCR) && (axi_awsize == FULL_SIZE));
    ast_ar_incr_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      axi_arvalid |-> (axi_arburst == AXI_INCR) && (axi_arsize == FULL_SIZE));
    ast_no_write_resp: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      corebus_sresp_valid |-> read_resp);
    ast_credit_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !((data_credit == '0) && wlast_hs && !aw_hs) && !((data_credit == FIFO_DEPTH) && aw_hs && !wlast_hs));
    ast_done_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !((done_count == FIFO_DEPTH) && wlast_hs && !b_hs));
    ast_fifo_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(fifo_full && aw_hs) && !((fifo_count == '0) && b_hs));
  end
endmodule

// File: tb/tb_pzcorebus_axi2corebus_simple_bridge.sv
// tb/tb_pzcorebus_axi2corebus_simple_bridge.sv - directed self-checking bench for the AXI to corebus bridge
`timescale 1ns/1ps
module tb_pzcorebus_axi2corebus_simple_bridge;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        axi_awvalid, axi_awready;
  logic [3:0]  axi_awid;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_wvalid, axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_bvalid, axi_bready;
  logic [3:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_arvalid, axi_arready;
  logic [3:0]  axi_arid;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_rvalid, axi_rready;
  logic [3:0]  axi_rid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        corebus_mcmd_valid, corebus_scmd_accept;
  logic [1:0]  corebus_mcmd;
  logic [3:0]  corebus_mid;
  logic [31:0] corebus_maddr;
  logic [7:0]  corebus_mlength;
  logic        corebus_mdata_valid, corebus_sdata_accept;
  logic [31:0] corebus_mdata;
  logic [3:0]  corebus_mdata_byteen;
  logic        corebus_mdata_last;
  logic        corebus_sresp_valid, corebus_mresp_accept;
  logic        corebus_sresp;
  logic [3:0]  corebus_sid;
  logic        corebus_serror;
  logic [31:0] corebus_sdata;
  logic [1:0]  corebus_sresp_last;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  pzcorebus_axi2corebus_simple_bridge dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bid(axi_bid), .axi_bresp(axi_bresp),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .corebus_mcmd_valid(corebus_mcmd_valid), .corebus_scmd_accept(corebus_scmd_accept), .corebus_mcmd(corebus_mcmd),
    .corebus_mid(corebus_mid), .corebus_maddr(corebus_maddr), .corebus_mlength(corebus_mlength),
    .corebus_mdata_valid(corebus_mdata_valid), .corebus_sdata_accept(corebus_sdata_accept), .corebus_mdata(corebus_mdata),
    .corebus_mdata_byteen(corebus_mdata_byteen), .corebus_mdata_last(corebus_mdata_last),
    .corebus_sresp_valid(corebus_sresp_valid), .corebus_mresp_accept(corebus_mresp_accept), .corebus_sresp(corebus_sresp),
    .corebus_sid(corebus_sid), .corebus_serror(corebus_serror), .corebus_sdata(corebus_sdata),
    .corebus_sresp_last(corebus_sresp_last)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    axi_awvalid = 0; axi_awid = 0; axi_awaddr = 0; axi_awlen = 0; axi_awsize = 3'd2; axi_awburst = 2'b01;
    axi_wvalid = 0; axi_wdata = 0; axi_wstrb = 4'hF; axi_wlast = 0; axi_bready = 0;
    axi_arvalid = 0; axi_arid = 0; axi_araddr = 0; axi_arlen = 0; axi_arsize = 3'd2; axi_arburst = 2'b01;
    axi_rready = 0; corebus_scmd_accept = 1; corebus_sdata_accept = 1;
    corebus_sresp_valid = 0; corebus_sresp = 1; corebus_sid = 0; corebus_serror = 0; corebus_sdata = 0;
    corebus_sresp_last = 0;
  endtask

  task automatic drain_writes(input int n);
    int beats = 0;
    int bhs = 0;
    int cycles = 0;
    while ((beats < n || bhs < n) && cycles < 50) begin
      axi_wvalid = (beats < n); axi_wlast = 1; axi_bready = 1;
      #1;
      if (axi_wvalid && axi_wready) beats++;
      if (axi_bvalid) bhs++;
      tick();
      cycles++;
    end
    axi_wvalid = 0; axi_bready = 0;
    vectors++; if (beats != n || bhs != n) begin miscompares++; $display("FAIL drain_timeout: beats %0d bresp %0d required %0d", beats, bhs, n); end
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst_n = 0;
    axi_awvalid = 1; axi_arvalid = 1; axi_wvalid = 1;
    #1;
    vectors++; if (corebus_mcmd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mcmd_valid: got %b required 0", corebus_mcmd_valid); end
    vectors++; if (corebus_mdata_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mdata_valid: got %b required 0", corebus_mdata_valid); end
    vectors++; if (axi_bvalid !== 1'b0) begin miscompares++; $display("FAIL rst_bvalid: got %b required 0", axi_bvalid); end
    vectors++; if (axi_awready !== 1'b0) begin miscompares++; $display("FAIL rst_awready: got %b required 0", axi_awready); end
    vectors++; if (axi_arready !== 1'b0) begin miscompares++; $display("FAIL rst_arready: got %b required 0", axi_arready); end
    idle_inputs();
    tick(); tick();
    i_rst_n = 1;
    tick();
  endtask

  task automatic test_single_write();
    axi_awvalid = 1; axi_awid = 3; axi_awaddr = 32'h1000; axi_awlen = 3; axi_bready = 1;
    for (int i = 0; i < 4; i++) begin
      axi_wvalid = 1; axi_wdata = 32'hA0 + i; axi_wstrb = 4'h5 + 4'(i); axi_wlast = (i == 3);
      #1;
      if (i == 0) begin
        vectors++; if (axi_awready !== 1'b1) begin miscompares++; $display("FAIL sw_awready: got %b required 1", axi_awready); end
        vectors++; if (corebus_mcmd !== CMD_WRITE) begin miscompares++; $display("FAIL sw_mcmd: got %b required %b", corebus_mcmd, CMD_WRITE); end
        vectors++; if (corebus_mid !== 4'd3) begin miscompares++; $display("FAIL sw_mid: got %0d required 3", corebus_mid); end
        vectors++; if (corebus_maddr !== 32'h1000) begin miscompares++; $display("FAIL sw_maddr: got %h required 00001000", corebus_maddr); end
        vectors++; if (corebus_mlength !== 8'd4) begin miscompares++; $display("FAIL sw_mlength: got %0d required 4", corebus_mlength); end
      end
      vectors++; if (corebus_mdata_valid !== 1'b1) begin miscompares++; $display("FAIL sw_mdata_valid beat %0d: got %b required 1", i, corebus_mdata_valid); end
      vectors++; if (corebus_mdata !== 32'hA0 + i) begin miscompares++; $display("FAIL sw_mdata beat %0d: got %h required %h", i, corebus_mdata, 32'hA0 + i); end
      vectors++; if (corebus_mdata_byteen !== 4'h5 + 4'(i)) begin miscompares++; $display("FAIL sw_byteen beat %0d: got %h required %h", i, corebus_mdata_byteen, 4'h5 + 4'(i)); end
      vectors++; if (corebus_mdata_last !== (i == 3)) begin miscompares++; $display("FAIL sw_mdata_last beat %0d: got %b required %b", i, corebus_mdata_last, (i == 3)); end
      vectors++; if (axi_bvalid !== 1'b0) begin miscompares++; $display("FAIL sw_early_bvalid beat %0d: got %b required 0", i, axi_bvalid); end
      tick();
      axi_awvalid = 0;
    end
    axi_wvalid = 0; axi_wlast = 0;
    #1;
    vectors++; if (axi_bvalid !== 1'b1) begin miscompares++; $display("FAIL sw_bvalid: got %b required 1", axi_bvalid); end
    vectors++; if (axi_bid !== 4'd3) begin miscompares++; $display("FAIL sw_bid: got %0d required 3", axi_bid); end
    vectors++; if (axi_bresp !== 2'b00) begin miscompares++; $display("FAIL sw_bresp: got %b required 00", axi_bresp); end
    tick();
    vectors++; if (axi_bvalid !== 1'b0) begin miscompares++; $display("FAIL sw_bvalid_pop: got %b required 0", axi_bvalid); end
    axi_bready = 0;
  endtask

  task automatic test_arbitration();
    axi_awvalid = 1; axi_awid = 5; axi_awaddr = 32'h2000; axi_awlen = 0;
    axi_arvalid = 1; axi_arid = 6; axi_araddr = 32'h3000; axi_arlen = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (corebus_mcmd !== ((k % 2 == 0) ? CMD_READ : CMD_WRITE)) begin miscompares++; $display("FAIL arb_order %0d: got %b required %b", k, corebus_mcmd, (k % 2 == 0) ? CMD_READ : CMD_WRITE); end
      vectors++; if ({axi_arready, axi_awready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL arb_ready %0d: got %b required %b", k, {axi_arready, axi_awready}, (k % 2 == 0) ? 2'b10 : 2'b01); end
      vectors++; if (corebus_mid !== ((k % 2 == 0) ? 4'd6 : 4'd5)) begin miscompares++; $display("FAIL arb_mid %0d: got %0d required %0d", k, corebus_mid, (k % 2 == 0) ? 6 : 5); end
      tick();
    end
    axi_awvalid = 0; axi_arvalid = 0;
    drain_writes(2);
    corebus_scmd_accept = 0; axi_awvalid = 1;
    #1;
    vectors++; if (corebus_mcmd !== CMD_WRITE || axi_awready !== 1'b0) begin miscompares++; $display("FAIL lock_stall: got mcmd %b awready %b required %b 0", corebus_mcmd, axi_awready, CMD_WRITE); end
    tick();
    axi_arvalid = 1;
    #1;
    vectors++; if (corebus_mcmd !== CMD_WRITE) begin miscompares++; $display("FAIL lock_hold: got %b required %b", corebus_mcmd, CMD_WRITE); end
    corebus_scmd_accept = 1;
    #1;
    vectors++; if ({axi_arready, axi_awready} !== 2'b01) begin miscompares++; $display("FAIL lock_release: got %b required 01", {axi_arready, axi_awready}); end
    tick();
    axi_awvalid = 0; axi_arlen = 8'hFF;
    #1;
    vectors++; if (axi_arready !== 1'b1 || corebus_mlength !== 8'd0) begin miscompares++; $display("FAIL max_len: got arready %b mlength %0d required 1 0", axi_arready, corebus_mlength); end
    tick();
    axi_arvalid = 0; axi_arlen = 0;
    drain_writes(1);
  endtask

  task automatic test_outstanding_limit();
    axi_bready = 0; axi_awlen = 0;
    for (int i = 0; i < 5; i++) begin
      axi_awvalid = 1; axi_awid = 4'(i + 1); axi_wvalid = 1; axi_wlast = 1; axi_wdata = 32'(i);
      #1;
      vectors++; if (axi_awready !== (i < 4)) begin miscompares++; $display("FAIL lim_awready %0d: got %b required %b", i, axi_awready, (i < 4)); end
      if (i < 4) tick();
    end
    vectors++; if (axi_wready !== 1'b0 || corebus_mcmd_valid !== 1'b0) begin miscompares++; $display("FAIL lim_blocked: got wready %b mcmd_valid %b required 0 0", axi_wready, corebus_mcmd_valid); end
    vectors++; if (axi_bvalid !== 1'b1 || axi_bid !== 4'd1) begin miscompares++; $display("FAIL lim_bhead: got bvalid %b bid %0d required 1 1", axi_bvalid, axi_bid); end
    tick();
    axi_bready = 1;
    #1;
    vectors++; if (axi_bid !== 4'd1 || axi_awready !== 1'b0) begin miscompares++; $display("FAIL lim_pop: got bid %0d awready %b required 1 0", axi_bid, axi_awready); end
    tick();
    axi_bready = 0;
    #1;
    vectors++; if (axi_awready !== 1'b1 || axi_wready !== 1'b1) begin miscompares++; $display("FAIL lim_fifth: got awready %b wready %b required 1 1", axi_awready, axi_wready); end
    tick();
    axi_awvalid = 0; axi_wvalid = 0; axi_bready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (axi_bvalid !== 1'b1 || axi_bid !== 4'(k + 2)) begin miscompares++; $display("FAIL lim_border %0d: got bvalid %b bid %0d required 1 %0d", k, axi_bvalid, axi_bid, k + 2); end
      tick();
    end
    vectors++; if (axi_bvalid !== 1'b0) begin miscompares++; $display("FAIL lim_empty: got %b required 0", axi_bvalid); end
    axi_bready = 0;
  endtask

  task automatic test_w_before_aw();
    axi_wvalid = 1; axi_wdata = 32'h55; axi_wlast = 1; axi_wstrb = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++; if (axi_wready !== 1'b0 || corebus_mdata_valid !== 1'b0) begin miscompares++; $display("FAIL wfirst_gate %0d: got wready %b mdata_valid %b required 0 0", k, axi_wready, corebus_mdata_valid); end
      tick();
    end
    axi_awvalid = 1; axi_awid = 9; axi_awlen = 0;
    #1;
    vectors++; if (axi_awready !== 1'b1 || axi_wready !== 1'b1 || corebus_mdata_valid !== 1'b1) begin miscompares++; $display("FAIL wfirst_release: got awready %b wready %b mdata_valid %b required 1 1 1", axi_awready, axi_wready, corebus_mdata_valid); end
    vectors++; if (corebus_mdata !== 32'h55) begin miscompares++; $display("FAIL wfirst_data: got %h required 00000055", corebus_mdata); end
    tick();
    axi_awvalid = 0; axi_wvalid = 0; axi_bready = 1;
    #1;
    vectors++; if (axi_bvalid !== 1'b1 || axi_bid !== 4'd9) begin miscompares++; $display("FAIL wfirst_b: got bvalid %b bid %0d required 1 9", axi_bvalid, axi_bid); end
    tick();
    axi_bready = 0;
  endtask

  task automatic test_read_response();
    logic [31:0] rdat [2];
    int beat = 0;
    int cyc = 0;
    rdat[0] = 32'h1111_0000; rdat[1] = 32'h2222_0001;
    while (beat < 2 && cyc < 12) begin
      corebus_sresp_valid = 1; corebus_sresp = 1; corebus_sid = 7; corebus_serror = 1;
      corebus_sdata = rdat[beat]; corebus_sresp_last = {1'b0, beat == 1};
      axi_rready = cyc[0];
      #1;
      vectors++; if (axi_rvalid !== 1'b1 || axi_rid !== 4'd7 || axi_rresp !== 2'b10) begin miscompares++; $display("FAIL rd_hdr cyc %0d: got rvalid %b rid %0d rresp %b required 1 7 10", cyc, axi_rvalid, axi_rid, axi_rresp); end
      vectors++; if (axi_rdata !== rdat[beat] || axi_rlast !== (beat == 1)) begin miscompares++; $display("FAIL rd_beat cyc %0d: got data %h last %b required %h %b", cyc, axi_rdata, axi_rlast, rdat[beat], beat == 1); end
      vectors++; if (corebus_mresp_accept !== axi_rready) begin miscompares++; $display("FAIL rd_accept cyc %0d: got %b required %b", cyc, corebus_mresp_accept, axi_rready); end
      if (axi_rready) beat++;
      tick();
      cyc++;
    end
    vectors++; if (beat != 2) begin miscompares++; $display("FAIL rd_timeout: got %0d beats required 2", beat); end
    corebus_serror = 0; corebus_sid = 2; corebus_sresp_last = 2'b01; axi_rready = 1;
    #1;
    vectors++; if (axi_rresp !== 2'b00 || axi_rlast !== 1'b1 || axi_rid !== 4'd2) begin miscompares++; $display("FAIL rd_okay: got rresp %b rlast %b rid %0d required 00 1 2", axi_rresp, axi_rlast, axi_rid); end
    tick();
    corebus_sresp_valid = 0; axi_rready = 0;
    #1;
    vectors++; if (axi_rvalid !== 1'b0) begin miscompares++; $display("FAIL rd_idle: got %b required 0", axi_rvalid); end
  endtask

  task automatic test_reset_mid_burst();
    axi_bready = 0;
    axi_awvalid = 1; axi_awid = 4; axi_awlen = 0; axi_wvalid = 1; axi_wlast = 1;
    tick();
    axi_awid = 2; axi_awlen = 3; axi_wlast = 0;
    tick();
    axi_awvalid = 0;
    tick();
    axi_arvalid = 1; corebus_scmd_accept = 0;
    #1;
    vectors++; if ({axi_bvalid, corebus_mcmd_valid, corebus_mdata_valid} !== 3'b111) begin miscompares++; $display("FAIL mid_pre: got %b required 111", {axi_bvalid, corebus_mcmd_valid, corebus_mdata_valid}); end
    i_rst_n = 0;
    #1;
    vectors++; if ({axi_bvalid, corebus_mcmd_valid, corebus_mdata_valid} !== 3'b000) begin miscompares++; $display("FAIL mid_async: got %b required 000", {axi_bvalid, corebus_mcmd_valid, corebus_mdata_valid}); end
    idle_inputs();
    tick(); tick();
    i_rst_n = 1;
    tick();
    vectors++; if (axi_bvalid !== 1'b0) begin miscompares++; $display("FAIL mid_stale_b: got %b required 0", axi_bvalid); end
    axi_awvalid = 1; axi_awid = 4'hA; axi_awlen = 1; axi_wvalid = 1; axi_wlast = 0;
    #1;
    vectors++; if (axi_awready !== 1'b1 || corebus_mlength !== 8'd2) begin miscompares++; $display("FAIL mid_fresh_aw: got awready %b mlength %0d required 1 2", axi_awready, corebus_mlength); end
    tick();
    axi_awvalid = 0; axi_wlast = 1;
    tick();
    axi_wvalid = 0; axi_bready = 1;
    #1;
    vectors++; if (axi_bvalid !== 1'b1 || axi_bid !== 4'hA) begin miscompares++; $display("FAIL mid_fresh_b: got bvalid %b bid %0d required 1 10", axi_bvalid, axi_bid); end
    tick();
    vectors++; if (axi_bvalid !== 1'b0) begin miscompares++; $display("FAIL mid_fresh_pop: got %b required 0", axi_bvalid); end
    axi_bready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_arbitration();
    test_outstanding_limit();
    test_w_before_aw();
    test_read_response();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
